key_search_ctrl: RTL and testbench

- Sequential tag-search controller for the hash processor. It owns a small table of DEPTH keys with per-entry valid bits.
- On request it scans the table one entry per cycle through a single shared N-bit equality compare (a == b, i.e. XOR-reduce-NOR) and reports the first matching index.
- It sits between the hash front end, which issues Start/Key, and the bucket logic, which consumes Done/Hit/HitIdx.

---
 rtl/key_search_ctrl.sv | 136 +++++++++++++
 tb/tb_key_search_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/key_search_ctrl.sv
// rtl/key_search_ctrl.sv - sequential first-match key search over a small valid-tagged table
// One shared equality compare walks the table one entry per cycle and reports the lowest hit.
module key_search_ctrl #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WrEn,
  input  logic [IDX_W-1:0] WrIdx,
  input  logic [N-1:0]     WrData,
  input  logic             ClrAll,
  input  logic             Start,
  input  logic [N-1:0]     Key,
  output logic             Busy,
  output logic             Done,
  output logic             Hit,
  output logic [IDX_W-1:0] HitIdx
);

  typedef enum logic {IDLE, SEARCH} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   DEPTH_W  = (IDX_W + 1)'(DEPTH);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       key_q, key_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic [N-1:0]       table_q [DEPTH];

  logic match;
  logic wr_ok;

  // The compare sees only registered contents, so a same-cycle write to the scanned entry is invisible.
  always_comb begin
    match = valid_q[idx_q] & (table_q[idx_q] == key_q);
    wr_ok = WrEn & ~ClrAll & ({1'b0, WrIdx} < DEPTH_W);

    state_d   = state_q;
    idx_d     = idx_q;
    key_d     = key_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;

    if (wr_ok) begin
      valid_d[WrIdx] = 1'b1;
    end

    if (ClrAll) begin
      valid_d = '0;
      if (state_q == SEARCH) begin
        state_d   = IDLE;
        idx_d     = '0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        hit_d     = 1'b0;
        hit_idx_d = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            key_d   = Key;
            idx_d   = '0;
            state_d = SEARCH;
            busy_d  = 1'b1;
          end
        end
        SEARCH: begin
          if (match) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            hit_d     = 1'b1;
            hit_idx_d = idx_q;
            idx_d     = '0;
          end else if (idx_q == LAST_IDX) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            hit_d     = 1'b0;
            hit_idx_d = '0;
            idx_d     = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      key_q     <= '0;
      valid_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
    end
  end

  // Table storage carries no reset; entries are meaningless until their valid bit is set.
  always_ff @(posedge Clk) begin
    if (wr_ok) begin
      table_q[WrIdx] <= WrData;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Hit    = hit_q;
  assign HitIdx = hit_idx_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// tb/tb_key_search_ctrl.sv - bench for key_search_ctrl
// Directed scenarios followed by randomized table/search rounds checked against a first-match model.
module tb_key_search_ctrl;

  logic        Clk, Reset, WrEn, ClrAll, Start;
  logic [2:0]  WrIdx;
  logic [31:0] WrData, Key;
  logic        Busy, Done, Hit;
  logic [2:0]  HitIdx;

  int total = 0;
  int bad   = 0;

  logic [31:0] mtab [8];
  bit          mval [8];

  key_search_ctrl #(.N(32), .DEPTH(8), .IDX_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrIdx(WrIdx), .WrData(WrData),
    .ClrAll(ClrAll), .Start(Start), .Key(Key), .Busy(Busy), .Done(Done),
    .Hit(Hit), .HitIdx(HitIdx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Lowest valid index holding key, or -1.
  function automatic int exp_idx(input logic [31:0] k);
    for (int i = 0; i < 8; i++) if (mval[i] && mtab[i] == k) return i;
    return -1;
  endfunction

  function automatic int exp_lat(input int e);
    return (e < 0) ? 8 : e + 1;
  endfunction

  task automatic wr(input int idx, input logic [31:0] d);
    WrEn = 1'b1; WrIdx = 3'(idx); WrData = d;
    tick();
    WrEn = 1'b0;
    mtab[idx] = d; mval[idx] = 1'b1;
  endtask

  task automatic clr_idle();
    ClrAll = 1'b1;
    tick();
    ClrAll = 1'b0;
    for (int i = 0; i < 8; i++) mval[i] = 1'b0;
  endtask

  task automatic launch(input logic [31:0] k);
    Key = k; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Continue counting cycles from 'already' until Done, sampling Busy each cycle.
  task automatic wait_done(input int already, output int lat, output int bcnt);
    lat = already; bcnt = already;
    while (Done !== 1'b1 && lat < 40) begin
      if (Busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic search_chk(input string tag, input logic [31:0] k);
    int e, lat, bc;
    e = exp_idx(k);
    launch(k);
    wait_done(0, lat, bc);
    chk({tag, "_lat"}, lat, exp_lat(e));
    chk({tag, "_busy"}, bc, exp_lat(e));
    chk({tag, "_hit"}, Hit, (e >= 0));
    chk({tag, "_idx"}, HitIdx, (e >= 0) ? e : 0);
  endtask

  initial begin
    int lat, bc, nw;
    logic [31:0] k;
    Reset = 1'b1; WrEn = 0; WrIdx = 0; WrData = 0; ClrAll = 0; Start = 0; Key = 0;
    for (int i = 0; i < 8; i++) begin mval[i] = 0; mtab[i] = 0; end
    #2;
    chk("rst_busy", Busy, 0); chk("rst_done", Done, 0);
    chk("rst_hit", Hit, 0);   chk("rst_idx", HitIdx, 0);
    #10 Reset = 1'b0;
    tick();

    search_chk("empty", 32'h0);

    wr(5, 32'hDEADBEEF);
    search_chk("e5", 32'hDEADBEEF);
    tick();
    chk("e5_done_pulse", Done, 0);
    chk("e5_hit_hold", Hit, 1);
    chk("e5_idx_hold", HitIdx, 5);

    wr(2, 32'h12345678); wr(6, 32'h12345678);
    search_chk("dup", 32'h12345678);
    search_chk("b2b", 32'h1);

    // Write a later entry mid-search: it is seen.
    launch(32'hCAFE0000);
    tick(); tick(); tick();
    WrEn = 1; WrIdx = 7; WrData = 32'hCAFE0000;
    tick();
    WrEn = 0; mtab[7] = 32'hCAFE0000; mval[7] = 1;
    wait_done(4, lat, bc);
    chk("late_wr_lat", lat, 8); chk("late_wr_hit", Hit, 1); chk("late_wr_idx", HitIdx, 7);

    // Write the entry under compare: that compare still misses.
    clr_idle();
    launch(32'hCAFE0000);
    tick(); tick(); tick();
    WrEn = 1; WrIdx = 3; WrData = 32'hCAFE0000;
    tick();
    WrEn = 0; mtab[3] = 32'hCAFE0000; mval[3] = 1;
    wait_done(4, lat, bc);
    chk("same_wr_lat", lat, 8); chk("same_wr_hit", Hit, 0);
    search_chk("same_wr_after", 32'hCAFE0000);

    // ClrAll aborts at idx 4 and drops a same-cycle write.
    wr(0, 32'h0000A5A5); wr(6, 32'h00000077);
    launch(32'h00000077);
    tick(); tick(); tick(); tick();
    ClrAll = 1; WrEn = 1; WrIdx = 0; WrData = 32'h00000077;
    tick();
    ClrAll = 0; WrEn = 0;
    for (int i = 0; i < 8; i++) mval[i] = 0;
    chk("clr_done", Done, 1); chk("clr_hit", Hit, 0);
    chk("clr_idx", HitIdx, 0); chk("clr_busy", Busy, 0);
    search_chk("clr_after", 32'h00000077);
    search_chk("clr_after_a5", 32'h0000A5A5);

    // ClrAll together with Start in IDLE: the start is ignored.
    Key = 32'h0; Start = 1; ClrAll = 1;
    tick();
    Start = 0; ClrAll = 0;
    chk("clr_start_busy", Busy, 0);

    // Start while busy is ignored, including its key.
    wr(1, 32'h55);
    launch(32'h99);
    tick();
    Key = 32'h55; Start = 1;
    tick();
    Start = 0;
    wait_done(2, lat, bc);
    chk("busy_start_lat", lat, 8); chk("busy_start_hit", Hit, 0);
    tick();
    chk("busy_start_nodone", Done, 0);
    chk("busy_start_idle", Busy, 0);

    // Async reset mid-search.
    search_chk("pre_rst", 32'h55);
    launch(32'h99);
    tick();
    #2 Reset = 1'b1;
    #1;
    chk("arst_busy", Busy, 0); chk("arst_done", Done, 0);
    chk("arst_hit", Hit, 0);   chk("arst_idx", HitIdx, 0);
    #1 Reset = 1'b0;
    for (int i = 0; i < 8; i++) mval[i] = 0;
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Done === 1'b1) nw++;
    end
    chk("arst_no_done", nw, 0);
    search_chk("arst_after", 32'h55);

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 5) == 0) clr_idle();
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        wr($urandom_range(0, 7), ($urandom_range(0, 1) == 1) ? $urandom : 32'h100 + $urandom_range(0, 3));
      k = 32'h100 + $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) k = $urandom;
      search_chk($sformatf("rnd%0d", r), k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
